uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
UART transmitter, the counterpart of the UART receiver FSM/sampler path. It accepts a parallel word with a one-cycle valid strobe and serialises it on TX_OUT as start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and one stop bit. Each bit lasts Prescale CLK cycles, using the same Prescale encoding as the receiver, so one Prescale value configures both ends. It sits between the system-side register/FIFO and the serial pin.

Parameters:
DATA_WIDTH, 8, width of the parallel data word.
PRESCALE_WIDTH, 6, width of the Prescale input and the internal edge counter.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  reset, synchronous, active-high.
P_DATA  input  DATA_WIDTH  word to transmit; sampled only on acceptance.
Data_Valid  input  1  request strobe; accepted only when busy=0.
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; sampled on acceptance.
TX_OUT  output  1  serial line, registered; idle level 1.
busy  output  1  registered; 1 from the acceptance edge until the frame ends.
tx_done  output  1  registered one-cycle pulse on the edge the frame completes.

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE, TX_OUT=1, busy=0, tx_done=0, counters cleared, shadow registers cleared. Reset applies mid-frame too: the line returns to 1 on the next cycle and the frame is abandoned with no tx_done.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. Data_Valid=1 at edge k is an acceptance:
  - latch P_DATA, PAR_EN, PAR_TYP and Prescale (a latched value of 0 is treated as 1);
  - compute parity bit: ^P_DATA if PAR_TYP=0, ~^P_DATA if PAR_TYP=1;
  - go to START, with TX_OUT=0 and busy=1 from cycle k+1.
- Bit timing: edge counter runs 0..Ps-1 inside each bit, where Ps is the latched Prescale. The bit (or state) advances on the edge where the counter equals Ps-1; the counter then wraps to 0.
- START: TX_OUT=0 for Ps cycles, then DATA.
- DATA: TX_OUT = data[bit_cnt], with bit_cnt 0..DATA_WIDTH-1, each for Ps cycles. After the last bit, go to PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY: TX_OUT = latched parity bit for Ps cycles, then STOP.
- STOP: TX_OUT=1 for Ps cycles. At the final edge: go to IDLE, busy=0, tx_done=1 for exactly one cycle.
- Frame length F = 1 + DATA_WIDTH + PAR_EN + 1 bits.
  - First start cycle: k+1. Last stop cycle: k+F*Ps.
  - busy falls and tx_done pulses at edge k+F*Ps.
  - Earliest next acceptance: edge k+F*Ps+1, giving a minimum of 1 extra idle-high cycle between frames.
- Data_Valid while busy=1 is ignored, not queued. P_DATA, PAR_EN, PAR_TYP and Prescale changes mid-frame have no effect.
- Data_Valid coincident with RST: reset wins, no acceptance.
- TX_OUT is driven from a flop only; no combinational path from inputs to TX_OUT.
- Counter widths: edge counter is PRESCALE_WIDTH bits; bit counter is ceil(log2(DATA_WIDTH+1)) bits, minimum 4. No overflow is possible for legal Prescale (1..2^PRESCALE_WIDTH-1).

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, Data_Valid pulse at edge k -> TX_OUT per 8-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1. busy high for cycles k+1..k+88. tx_done single pulse at edge k+88.
2. Prescale=16, PAR_EN=0, P_DATA=0x3C -> bits 0,0,0,1,1,1,1,0,0,1. Frame is 160 cycles, with no parity slot.
3. Prescale=4, PAR_EN=1, PAR_TYP=1, P_DATA=0x07 -> parity bit 0. Repeat with 0x03 -> parity bit 1. Frame is 44 cycles.
4. Data_Valid held high continuously, P_DATA 0x55 then 0xAA, Prescale=4, no parity -> back-to-back frames with exactly one idle-high cycle between stop and start; the second frame carries the P_DATA value present on its acceptance edge.
5. Data_Valid pulse with P_DATA=0xFF in the middle of a 0x00 frame; also change Prescale mid-frame -> ignored: the first frame is unchanged, no second frame, tx_done pulses once.
6. RST=1 during DATA bit 3 -> next cycle TX_OUT=1, busy=0, no tx_done. A new Data_Valid after reset release transmits a full, correct frame.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Every bit is held for Prescale clock cycles; TX_OUT, busy and tx_done are all flop outputs.
module uart_tx_fsm #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      TX_OUT,
   output logic                      busy,
   output logic                      tx_done
);

   localparam int BIT_CNT_RAW = $clog2(DATA_WIDTH + 1);
   localparam int BIT_CNT_W   = (BIT_CNT_RAW > 4) ? BIT_CNT_RAW : 4;
   localparam int IDX_RAW     = $clog2(DATA_WIDTH);
   localparam int IDX_W       = (IDX_RAW > 1) ? IDX_RAW : 1;

   localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = PRESCALE_WIDTH'(1);
   localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = BIT_CNT_W'(1);
   localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

   state_t                    state_q, state_d;
   logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      par_en_q, par_en_d;
   logic                      par_bit_q, par_bit_d;
   logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
   logic                      tx_out_q, tx_out_d;
   logic                      busy_q, busy_d;
   logic                      tx_done_q, tx_done_d;
   logic                      bit_end_s;
   logic [IDX_W-1:0]          bit_idx_s;

   // Next-state, shadow-register and registered-output logic.
   always_comb begin
      state_d    = state_q;
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      ps_d       = ps_q;
      tx_done_d  = 1'b0;
      tx_out_d   = 1'b1;
      bit_end_s  = (edge_cnt_q == (ps_q - PS_ONE));

      if (state_q == IDLE) begin
         edge_cnt_d = '0;
      end else if (bit_end_s) begin
         edge_cnt_d = '0;
      end else begin
         edge_cnt_d = edge_cnt_q + PS_ONE;
      end

      case (state_q)
         IDLE: begin
            if (Data_Valid) begin
               data_d    = P_DATA;
               par_en_d  = PAR_EN;
               par_bit_d = parity_bit(P_DATA, PAR_TYP);
               ps_d      = (Prescale == '0) ? PS_ONE : Prescale;
               bit_cnt_d = '0;
               state_d   = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               bit_cnt_d = '0;
               state_d   = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_end_s && (bit_cnt_q == LAST_BIT)) begin
               bit_cnt_d = '0;
               state_d   = par_en_q ? PARITY : STOP;
            end else if (bit_end_s) begin
               bit_cnt_d = bit_cnt_q + BIT_ONE;
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               state_d   = IDLE;
               tx_done_d = 1'b1;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The line level is chosen from the upcoming state so TX_OUT changes exactly on the bit edge.
      bit_idx_s = bit_cnt_d[IDX_W-1:0];
      case (state_d)
         IDLE:    tx_out_d = 1'b1;
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = data_q[bit_idx_s];
         PARITY:  tx_out_d = par_bit_q;
         STOP:    tx_out_d = 1'b1;
         default: tx_out_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, counters, shadow copies of the request and output flops.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         ps_q       <= PS_ONE;
         tx_out_q   <= 1'b1;
         busy_q     <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         ps_q       <= ps_d;
         tx_out_q   <= tx_out_d;
         busy_q     <= busy_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign TX_OUT  = tx_out_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed self-checking bench for uart_tx_fsm; outputs are sampled on the falling edge.
module tb_uart_tx_fsm;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       busy;
   logic       tx_done;

   int total_cnt = 0;
   int bad_cnt   = 0;

   uart_tx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .Prescale  (Prescale),
      .TX_OUT    (TX_OUT),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Present a request at a falling edge; returns just after the acceptance edge.
   task automatic send(input logic [7:0] d, input logic [5:0] ps, input logic pen, input logic ptyp);
      @(negedge CLK);
      P_DATA     = d;
      Prescale   = ps;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
      @(posedge CLK);
   endtask

   // Follow one whole frame cycle by cycle, ending on the cycle after the tx_done edge.
   task automatic watch(input logic [7:0] d, input int ps, input logic pen, input logic par,
                        input bit hold, input bit disturb);
      int   frame_len;
      int   idx;
      logic exp_bit;
      frame_len = 10 + (pen ? 1 : 0);
      for (int j = 1; j <= frame_len * ps; j++) begin
         @(negedge CLK);
         if (j == 1 && !hold) Data_Valid = 1'b0;
         if (j == 1 && hold) P_DATA = ~d;
         if (disturb && j == 30) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
            Prescale   = 6'd3;
         end
         if (disturb && j == 31) Data_Valid = 1'b0;
         idx = (j - 1) / ps;
         if (idx == 0) exp_bit = 1'b0;
         else if (idx <= 8) exp_bit = d[idx-1];
         else if (pen && idx == 9) exp_bit = par;
         else exp_bit = 1'b1;
         check_val("tx_bit", {31'd0, TX_OUT}, {31'd0, exp_bit});
         check_val("busy_in_frame", {31'd0, busy}, 32'd1);
         check_val("done_in_frame", {31'd0, tx_done}, 32'd0);
      end
      @(negedge CLK);
      check_val("done_pulse", {31'd0, tx_done}, 32'd1);
      check_val("busy_end", {31'd0, busy}, 32'd0);
      check_val("tx_end", {31'd0, TX_OUT}, 32'd1);
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         check_val("idle_tx", {31'd0, TX_OUT}, 32'd1);
         check_val("idle_busy", {31'd0, busy}, 32'd0);
         check_val("idle_done", {31'd0, tx_done}, 32'd0);
      end
   endtask

   initial begin
      RST        = 1'b1;
      Data_Valid = 1'b0;
      P_DATA     = 8'h00;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Prescale   = 6'd4;
      repeat (2) @(negedge CLK);
      check_val("rst_tx", {31'd0, TX_OUT}, 32'd1);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, tx_done}, 32'd0);
      // Request during reset must not be accepted.
      Data_Valid = 1'b1;
      @(negedge CLK);
      check_val("rst_dv_busy", {31'd0, busy}, 32'd0);
      check_val("rst_dv_tx", {31'd0, TX_OUT}, 32'd1);
      Data_Valid = 1'b0;
      RST        = 1'b0;
      idle_check(3);

      // 0xA5, even parity bit 0, Prescale 8
      send(8'hA5, 6'd8, 1'b1, 1'b0);
      watch(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(3);

      // 0x3C, no parity, Prescale 16
      send(8'h3C, 6'd16, 1'b0, 1'b0);
      watch(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_check(3);

      // Odd parity: 0x07 -> 0, 0x03 -> 1
      send(8'h07, 6'd4, 1'b1, 1'b1);
      watch(8'h07, 4, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(3);
      send(8'h03, 6'd4, 1'b1, 1'b1);
      watch(8'h03, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_check(3);

      // Back-to-back with Data_Valid held: 0x55 then 0xAA after one idle cycle
      send(8'h55, 6'd4, 1'b0, 1'b0);
      watch(8'h55, 4, 1'b0, 1'b0, 1'b1, 1'b0);
      watch(8'hAA, 4, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_check(3);

      // Mid-frame request and Prescale change are ignored
      send(8'h00, 6'd8, 1'b0, 1'b0);
      watch(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check(20);

      // Prescale 0 behaves as 1; 0x96 odd parity -> 1
      send(8'h96, 6'd0, 1'b1, 1'b1);
      watch(8'h96, 1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_check(3);

      // Reset during data bit 3 of 0x5A (bit 3 = 1), Prescale 4
      send(8'h5A, 6'd4, 1'b0, 1'b0);
      for (int j = 1; j <= 18; j++) begin
         @(negedge CLK);
         if (j == 1) Data_Valid = 1'b0;
      end
      check_val("pre_rst_bit3", {31'd0, TX_OUT}, 32'd1);
      check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      check_val("mid_rst_tx", {31'd0, TX_OUT}, 32'd1);
      check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
      check_val("mid_rst_done", {31'd0, tx_done}, 32'd0);
      RST = 1'b0;
      idle_check(30);
      send(8'hC3, 6'd4, 1'b1, 1'b0);
      watch(8'hC3, 4, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_check(3);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
